key_cmd_sched: RTL and testbench



---
 rtl/key_cmd_sched_if.sv | 27 ++
 rtl/key_cmd_sched.sv | 166 ++++++++++++++++
 tb/tb_key_cmd_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/key_cmd_sched_if.sv
// Keypad-to-command scheduler bus: key events in, buffered game commands out.
// The master drives key events and consumes commands; the scheduler is the slave.
interface key_cmd_sched_if #(
  parameter int CNT_W = 3
);
  logic [4:0]       key_code;
  logic             key_strobe;
  logic             key_held;
  logic             tick;
  logic             cmd_ready;
  logic             clear_ovf;
  logic             cmd_valid;
  logic [4:0]       cmd_code;
  logic             cmd_is_repeat;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output key_code, key_strobe, key_held, tick, cmd_ready, clear_ovf,
    input  cmd_valid, cmd_code, cmd_is_repeat, fifo_count, overflow
  );

  modport slave (
    input  key_code, key_strobe, key_held, tick, cmd_ready, clear_ovf,
    output cmd_valid, cmd_code, cmd_is_repeat, fifo_count, overflow
  );
endinterface

// File: rtl/key_cmd_sched.sv
// Key command scheduler: turns key presses into game commands with frame-tick
// paced auto-repeat, buffered in a show-ahead FIFO with sticky overflow.
module key_cmd_sched #(
  parameter int          DELAY_TICKS  = 16,
  parameter int          REPEAT_TICKS = 4,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [19:0] REPEAT_MASK  = 20'h0000F
) (
  input logic             clk,
  input logic             rst,
  key_cmd_sched_if.slave  bus
);

  localparam int MAX_TICKS = (DELAY_TICKS > REPEAT_TICKS) ? DELAY_TICKS : REPEAT_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS) + 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int FCNT_W    = PTR_W + 1;
  // Widened so any 5-bit code indexes in range; codes 20..31 never repeat.
  localparam logic [31:0] MASK_EXT = {12'd0, REPEAT_MASK};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [4:0]        active_code_r;

  logic [5:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FCNT_W-1:0] count_r;
  logic              overflow_r;

  logic              strobe_ok_s;
  logic              rpt_fire_s;
  logic              push_s;
  logic [5:0]        push_data_s;
  logic              full_s;
  logic              pop_s;
  logic              wr_en_s;
  logic              drop_s;

  assign strobe_ok_s = bus.key_strobe && (bus.key_code <= 5'd19);

  // Repeat enqueue request: held key, expiring counter, not preempted by a press.
  always_comb begin
    rpt_fire_s = 1'b0;
    if (!strobe_ok_s && bus.key_held && bus.tick && (cnt_r == CNT_W'(1)) &&
        ((state_r == DELAY) || (state_r == REPEAT))) begin
      rpt_fire_s = 1'b1;
    end else begin
      rpt_fire_s = 1'b0;
    end
  end

  // Single enqueue source per cycle: a fresh press wins over a repeat.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = 6'd0;
    if (strobe_ok_s) begin
      push_s      = 1'b1;
      push_data_s = {1'b0, bus.key_code};
    end else if (rpt_fire_s) begin
      push_s      = 1'b1;
      push_data_s = {1'b1, active_code_r};
    end else begin
      push_s      = 1'b0;
      push_data_s = 6'd0;
    end
  end

  // Repeat FSM: press latches the code, held key counts frame ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      active_code_r <= 5'd0;
    end else if (strobe_ok_s) begin
      active_code_r <= bus.key_code;
      if (MASK_EXT[bus.key_code]) begin
        state_r <= DELAY;
        cnt_r   <= CNT_W'(DELAY_TICKS);
      end else begin
        state_r <= HOLD;
        cnt_r   <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        HOLD: begin
          if (!bus.key_held) state_r <= IDLE;
        end
        DELAY: begin
          if (!bus.key_held) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (bus.tick) begin
            if (cnt_r == CNT_W'(1)) begin
              state_r <= REPEAT;
              cnt_r   <= CNT_W'(REPEAT_TICKS);
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!bus.key_held) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (bus.tick) begin
            if (cnt_r == CNT_W'(1)) cnt_r <= CNT_W'(REPEAT_TICKS);
            else                    cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign full_s  = (count_r == FCNT_W'(FIFO_DEPTH));
  assign pop_s   = (count_r != FCNT_W'(0)) && bus.cmd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 6'd0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + FCNT_W'(1);
        2'b01:   count_r <= count_r - FCNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s)             overflow_r <= 1'b1;
      else if (bus.clear_ovf) overflow_r <= 1'b0;
      else                    overflow_r <= overflow_r;
    end
  end

  assign bus.cmd_valid     = (count_r != FCNT_W'(0));
  assign bus.cmd_code      = mem_r[rd_ptr_r][4:0];
  assign bus.cmd_is_repeat = mem_r[rd_ptr_r][5];
  assign bus.fifo_count    = count_r;
  assign bus.overflow      = overflow_r;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Bench for key_cmd_sched: directed scenarios plus random stimulus, all compared
// against a tick-counting reference model with a queue-based FIFO.
module tb_key_cmd_sched;

  localparam int          DELAY_TICKS  = 16;
  localparam int          REPEAT_TICKS = 4;
  localparam int          DEPTH        = 4;
  localparam logic [31:0] MASK         = 32'h0000_000F;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  key_cmd_sched_if #(.CNT_W(3)) bus ();

  key_cmd_sched #(
    .DELAY_TICKS (DELAY_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS),
    .FIFO_DEPTH  (DEPTH),
    .REPEAT_MASK (20'h0000F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 none, 1 held non-repeating, 2 held repeating.
  logic [5:0] q[$];
  int         m_mode;
  int         m_ticks;
  logic [4:0] m_code;
  logic       m_ovf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("cmd_valid", 32'(bus.cmd_valid), 32'(q.size() != 0));
    check_val("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    check_val("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (q.size() != 0) begin
      check_val("cmd_code", 32'(bus.cmd_code), 32'(q[0][4:0]));
      check_val("cmd_is_repeat", 32'(bus.cmd_is_repeat), 32'(q[0][5]));
    end
  endtask

  task automatic model_step(input logic s, input logic [4:0] c, input logic h,
                            input logic t, input logic r, input logic clr);
    logic       push;
    logic [5:0] pdata;
    logic       pop;
    logic       drop;
    push  = 1'b0;
    pdata = 6'd0;
    if (s && (c <= 5'd19)) begin
      push    = 1'b1;
      pdata   = {1'b0, c};
      m_code  = c;
      m_mode  = MASK[c] ? 2 : 1;
      m_ticks = 0;
    end else if (m_mode != 0 && !h) begin
      m_mode = 0;
    end else if (m_mode == 2 && t) begin
      m_ticks++;
      if (m_ticks >= DELAY_TICKS && ((m_ticks - DELAY_TICKS) % REPEAT_TICKS) == 0) begin
        push  = 1'b1;
        pdata = {1'b1, m_code};
      end
    end
    pop  = (q.size() != 0) && r;
    drop = push && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(pdata);
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic step(input logic s, input logic [4:0] c, input logic h,
                      input logic t, input logic r, input logic clr);
    @(negedge clk);
    check_outputs();
    bus.key_strobe = s;
    bus.key_code   = c;
    bus.key_held   = h;
    bus.tick       = t;
    bus.cmd_ready  = r;
    bus.clear_ovf  = clr;
    model_step(s, c, h, t, r, clr);
  endtask

  // n frame ticks, one every second cycle, key held as given.
  task automatic run_ticks(input int n, input logic h, input logic r);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 5'd0, h, 1'b0, r, 1'b0);
      step(1'b0, 5'd0, h, 1'b1, r, 1'b0);
    end
  endtask

  task automatic do_reset(input logic h);
    @(negedge clk);
    rst = 1'b1;
    bus.key_strobe = 1'b0;
    bus.key_held   = h;
    bus.tick       = 1'b0;
    bus.clear_ovf  = 1'b0;
    #1;
    check_val("rst_valid", 32'(bus.cmd_valid), 32'd0);
    check_val("rst_code", 32'(bus.cmd_code), 32'd0);
    check_val("rst_repeat", 32'(bus.cmd_is_repeat), 32'd0);
    check_val("rst_count", 32'(bus.fifo_count), 32'd0);
    check_val("rst_ovf", 32'(bus.overflow), 32'd0);
    q.delete();
    m_mode  = 0;
    m_ticks = 0;
    m_code  = 5'd0;
    m_ovf   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic       rs;
    logic [4:0] rc;
    logic       rh;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.key_code = 5'd0; bus.key_strobe = 1'b0; bus.key_held = 1'b0;
    bus.tick = 1'b0; bus.cmd_ready = 1'b0; bus.clear_ovf = 1'b0;
    do_reset(1'b0);

    // Non-repeating key held for 40 ticks: a single press command.
    step(1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    run_ticks(40, 1'b1, 1'b1);
    run_ticks(2, 1'b0, 1'b1);

    // Repeatable key held 24 ticks: press plus repeats at ticks 16, 20, 24.
    step(1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    run_ticks(24, 1'b1, 1'b1);
    run_ticks(6, 1'b0, 1'b1);

    // Release before the first repeat, then release coinciding with tick 16.
    step(1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_ticks(10, 1'b1, 1'b1);
    run_ticks(2, 1'b0, 1'b1);
    step(1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_ticks(15, 1'b1, 1'b1);
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_ticks(3, 1'b0, 1'b1);

    // Overflow with a stalled consumer, clear, then drain in order.
    step(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_ticks(3, 1'b0, 1'b1);

    // Full FIFO with pop and push in the same cycle.
    step(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    run_ticks(3, 1'b0, 1'b1);

    // Out-of-range code is ignored.
    step(1'b1, 5'd25, 1'b1, 1'b0, 1'b1, 1'b0);
    run_ticks(20, 1'b1, 1'b1);
    run_ticks(1, 1'b0, 1'b1);

    // Reset while repeating with two queued entries, key kept held after.
    step(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(17, 1'b1, 1'b0);
    do_reset(1'b1);
    run_ticks(30, 1'b1, 1'b1);
    run_ticks(1, 1'b0, 1'b1);

    // Random traffic.
    rh = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 39) == 0);
      rc = 5'($urandom_range(0, 24));
      if (rs) rh = 1'b1;
      else if ($urandom_range(0, 79) == 0) rh = 1'b0;
      else if (!rh && $urandom_range(0, 9) == 0) rh = 1'b1;
      step(rs, rc, rh, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0));
    end
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
